// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store, data side first with a fetch starvation guard.
// Define ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles (reply 0xDEADBEEF with an err pulse).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state;
  logic [3:0]        starve_cnt;
  logic              owner_dm;
  logic              resp_fire;
  logic              resp_err;
  logic [DATA_W-1:0] resp_word;

`ifdef ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;

  // What WAIT hands to RESP: the memory word (0 for stores) or, on timeout, the poison word.
  always_comb begin
    resp_fire = mem_valid;
    resp_word = mem_we ? '0 : mem_rdata;
    resp_err  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    if (!mem_valid && wait_cnt == WAIT_LAST) begin
      resp_fire = 1'b1;
      resp_word = DATA_W'(32'hDEADBEEF);
      resp_err  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_ready   <= 1'b0;
      dm_rdata   <= '0;
      err        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            // Fetch wins alone or once it has lost STARVE_MAX times in a row.
            if (if_req && (!dm_req || starve_cnt == STARVE_LIM)) begin
              owner_dm   <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              owner_dm  <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (if_req) starve_cnt <= starve_cnt + 4'd1;
            end
            mem_en <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state  <= WAIT;
        end
        WAIT: begin
          if (resp_fire) begin
            if (owner_dm) begin
              dm_ready <= 1'b1;
              dm_rdata <= resp_word;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= resp_word;
            end
            err   <= resp_err;
            state <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // Straight back to IDLE so a request still held during its ready pulse is not served twice.
          if_ready <= 1'b0;
          if_rdata <= '0;
          dm_ready <= 1'b0;
          dm_rdata <= '0;
          err      <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a timestamp model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req, dm_req, dm_we, mem_valid;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_ready, stall_if, dm_ready, stall_dm, mem_en, mem_we, err;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Transaction-level model: one access in flight, tracked by the absolute cycles of its phases.
  int          en_cyc, valid_cyc, rdy_cyc, free_cyc, starve;
  bit          t_dm, t_we;
  logic [31:0] t_addr, t_wdata, exp_rdata;
  bit          if_inflight, dm_inflight, if_done, dm_done, chk_on;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .stall_if(stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".mem_en"},    32'(mem_en),   0);
    checkVal({tag, ".mem_we"},    32'(mem_we),   0);
    checkVal({tag, ".mem_addr"},  mem_addr,      0);
    checkVal({tag, ".mem_wdata"}, mem_wdata,     0);
    checkVal({tag, ".if_ready"},  32'(if_ready), 0);
    checkVal({tag, ".if_rdata"},  if_rdata,      0);
    checkVal({tag, ".dm_ready"},  32'(dm_ready), 0);
    checkVal({tag, ".dm_rdata"},  dm_rdata,      0);
    checkVal({tag, ".err"},       32'(err),      0);
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  task automatic checkOutput();
    bit e_en, e_ifr, e_dmr;
    e_en  = (cyc == en_cyc);
    e_ifr = (cyc == rdy_cyc) && !t_dm;
    e_dmr = (cyc == rdy_cyc) && t_dm;
    checkVal("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      checkVal("mem_we",    32'(mem_we), 32'(t_we));
      checkVal("mem_addr",  mem_addr,    t_addr);
      checkVal("mem_wdata", mem_wdata,   t_wdata);
    end
    checkVal("if_ready", 32'(if_ready), 32'(e_ifr));
    checkVal("if_rdata", if_rdata, e_ifr ? exp_rdata : 32'h0);
    checkVal("dm_ready", 32'(dm_ready), 32'(e_dmr));
    checkVal("dm_rdata", dm_rdata, e_dmr ? exp_rdata : 32'h0);
    checkVal("stall_if", 32'(stall_if), 32'(if_req & ~e_ifr));
    checkVal("stall_dm", 32'(stall_dm), 32'(dm_req & ~e_dmr));
    checkVal("err", 32'(err), 0);
  endtask

  always @(negedge clk) if (chk_on) checkOutput();

  task automatic idleInputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_valid = 0; mem_rdata = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic doReset();
    rst_n = 0;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cyc = 0;
  endtask

  // Randomized requesters and memory for cycle cyc; requests hold until served, sometimes drop.
  task automatic applyStimulus();
    if (if_done) begin if_req = 0; if_done = 0; end
    if (if_inflight) begin
      if_addr = $urandom;
      if (if_req && $urandom_range(0, 15) == 0) if_req = 0;
    end else if (if_req) begin
      if ($urandom_range(0, 15) == 0) if_req = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      if_req = 1; if_addr = $urandom;
    end
    if (dm_done) begin dm_req = 0; dm_done = 0; end
    if (dm_inflight) begin
      dm_addr = $urandom; dm_wdata = $urandom; dm_we = $urandom_range(0, 1) == 1;
      if (dm_req && $urandom_range(0, 15) == 0) dm_req = 0;
    end else if (dm_req) begin
      if ($urandom_range(0, 15) == 0) dm_req = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      dm_req = 1; dm_addr = $urandom; dm_wdata = $urandom; dm_we = $urandom_range(0, 1) == 1;
    end
    mem_rdata = $urandom;
    if (cyc == valid_cyc)                     mem_valid = 1;
    else if (cyc > en_cyc && cyc < valid_cyc) mem_valid = 0;
    else                                      mem_valid = ($urandom_range(0, 3) == 0);
  endtask

  task automatic modelStep();
    bit pick_if;
    if (cyc == valid_cyc) exp_rdata = t_we ? 32'h0 : mem_rdata;
    if (cyc == rdy_cyc) begin
      if (t_dm) begin dm_inflight = 0; dm_done = 1; end
      else      begin if_inflight = 0; if_done = 1; end
    end
    if (cyc >= free_cyc && (if_req || dm_req)) begin
      pick_if = if_req && (!dm_req || starve == SMAX);
      if (pick_if) begin
        starve = 0; t_dm = 0; t_we = 0; t_addr = if_addr; t_wdata = 0; if_inflight = 1;
      end else begin
        if (if_req) starve = (starve < SMAX) ? starve + 1 : starve;
        t_dm = 1; t_we = dm_we; t_addr = dm_addr; t_wdata = dm_wdata; dm_inflight = 1;
      end
      en_cyc    = cyc + 1;
      valid_cyc = en_cyc + int'($urandom_range(1, 3));
      rdy_cyc   = valid_cyc + 1;
      free_cyc  = rdy_cyc + 1;
    end
  endtask

  task automatic testFetchAndReset();
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    checkVal("fetch.stall_c0", 32'(stall_if), 1);
    checkVal("fetch.mem_en_c0", 32'(mem_en), 0);
    nextCycle(); @(negedge clk);
    checkVal("fetch.mem_en_c1", 32'(mem_en), 1);
    checkVal("fetch.mem_addr_c1", mem_addr, 32'h40);
    checkVal("fetch.mem_we_c1", 32'(mem_we), 0);
    checkVal("fetch.stall_c1", 32'(stall_if), 1);
    nextCycle(); @(negedge clk);
    checkVal("fetch.mem_en_c2", 32'(mem_en), 0);
    checkVal("fetch.stall_c2", 32'(stall_if), 1);
    nextCycle(); mem_valid = 1; mem_rdata = 32'h00500093; @(negedge clk);
    checkVal("fetch.ready_c3", 32'(if_ready), 0);
    checkVal("fetch.stall_c3", 32'(stall_if), 1);
    nextCycle(); mem_valid = 0; mem_rdata = 0; @(negedge clk);
    checkVal("fetch.ready_c4", 32'(if_ready), 1);
    checkVal("fetch.rdata_c4", if_rdata, 32'h00500093);
    checkVal("fetch.stall_c4", 32'(stall_if), 0);
    checkVal("fetch.dm_ready_c4", 32'(dm_ready), 0);
    // Asynchronous reset between edges, while the ready pulse is up.
    #2 rst_n = 0;
    #1 checkAllZero("areset");
    checkVal("areset.stall_if", 32'(stall_if), 1);
    if_req = 0;
    @(negedge clk) rst_n = 1;
    nextCycle();
  endtask

  task automatic testStore();
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checkVal("store.stall_c0", 32'(stall_dm), 1);
    nextCycle(); dm_addr = 32'h999; dm_wdata = 32'h0; @(negedge clk);
    checkVal("store.mem_en", 32'(mem_en), 1);
    checkVal("store.mem_we", 32'(mem_we), 1);
    checkVal("store.mem_addr", mem_addr, 32'h100);
    checkVal("store.mem_wdata", mem_wdata, 32'hCAFEF00D);
    nextCycle(); mem_valid = 1; mem_rdata = 32'h12345678;
    nextCycle(); mem_valid = 0; @(negedge clk);
    checkVal("store.dm_ready", 32'(dm_ready), 1);
    checkVal("store.dm_rdata", dm_rdata, 0);
    checkVal("store.if_ready", 32'(if_ready), 0);
    checkVal("store.stall_dm", 32'(stall_dm), 0);
    nextCycle(); dm_req = 0; dm_we = 0; @(negedge clk);
    checkVal("store.ready_drop", 32'(dm_ready), 0);
  endtask

  task automatic testContention();
    int exp_dm[6];
    int t;
    exp_dm = '{1, 1, 0, 1, 1, 0};
    doReset();
    if_req = 1; if_addr = 32'h1000; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    for (int g = 0; g < 6; g++) begin
      t = 0;
      @(negedge clk);
      while (mem_en !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      checkVal($sformatf("contend.grant%0d_seen", g), 32'(mem_en), 1);
      checkVal($sformatf("contend.grant%0d_addr", g), mem_addr, exp_dm[g] != 0 ? 32'h2000 : 32'h1000);
      @(posedge clk); #1 mem_valid = 1; mem_rdata = 32'h11110000 + 32'(g);
      @(posedge clk); #1 mem_valid = 0;
      @(negedge clk);
      checkVal($sformatf("contend.resp%0d_dm", g), 32'(dm_ready), 32'(exp_dm[g]));
      checkVal($sformatf("contend.resp%0d_if", g), 32'(if_ready), 32'(exp_dm[g] == 0));
    end
    idleInputs();
  endtask

  task automatic testResetInWait();
    doReset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    nextCycle();
    nextCycle();
    #2 rst_n = 0;
    #1 checkAllZero("wreset");
    dm_req = 0;
    @(negedge clk) rst_n = 1;
    nextCycle(); mem_valid = 1; mem_rdata = 32'hBAD0BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal($sformatf("wreset.dm_ready%0d", k), 32'(dm_ready), 0);
      checkVal($sformatf("wreset.mem_en%0d", k), 32'(mem_en), 0);
      nextCycle(); mem_valid = 0;
    end
    dm_req = 1; dm_addr = 32'h300;
    nextCycle(); @(negedge clk);
    checkVal("wreset.next_en", 32'(mem_en), 1);
    checkVal("wreset.next_addr", mem_addr, 32'h300);
    nextCycle(); mem_valid = 1; mem_rdata = 32'h0000ABCD;
    nextCycle(); mem_valid = 0; @(negedge clk);
    checkVal("wreset.next_ready", 32'(dm_ready), 1);
    checkVal("wreset.next_rdata", dm_rdata, 32'h0000ABCD);
    nextCycle(); dm_req = 0;
  endtask

  task automatic testTimeout();
    int n;
    doReset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    n = 0;
`ifdef ARB_TIMEOUT_EN
    @(negedge clk);
    while (dm_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checkVal("timeout.latency", 32'(n), 18);
    checkVal("timeout.rdata", dm_rdata, 32'hDEADBEEF);
    checkVal("timeout.err", 32'(err), 1);
    @(posedge clk); #1 dm_req = 0;
    @(negedge clk);
    checkVal("timeout.err_drop", 32'(err), 0);
    checkVal("timeout.ready_drop", 32'(dm_ready), 0);
`else
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dm_ready === 1'b1 || err === 1'b1) n++;
    end
    checkVal("noto.ready_or_err", 32'(n), 0);
`endif
    doReset();
  endtask

  initial begin
    chk_on = 0;
    if_done = 0; dm_done = 0; if_inflight = 0; dm_inflight = 0;
    idleInputs();
    @(posedge clk); #1;
    checkAllZero("reset");
    doReset();
    testFetchAndReset();
    testStore();
    testContention();
    testResetInWait();
    testTimeout();

    doReset();
    en_cyc = -100; valid_cyc = -100; rdy_cyc = -100; free_cyc = 0; starve = 0;
    t_dm = 0; t_we = 0; t_addr = 0; t_wdata = 0; exp_rdata = 0;
    if_inflight = 0; dm_inflight = 0; if_done = 0; dm_done = 0;
    chk_on = 1;
    for (int k = 0; k < 3000; k++) begin
      applyStimulus();
      @(posedge clk);
      modelStep();
      cyc++;
      #1;
    end
    chk_on = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
